sdp_be_traffic_gen: RTL

SDP_BE_TRAFFIC_GEN -- requirements
Module: sdp_be_traffic_gen

---
 rtl/sdp_be_traffic_gen.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sdp_be_traffic_gen.sv
// Byte-enable RAM self-test: fills a pattern, overwrites one byte lane per word,
// reads back and counts mismatching words. Optional macro SDP_BE_TRAFFIC_GEN_STOP_ON_ERR_EN ends the test at the first mismatch.
module sdp_be_traffic_gen #(
    parameter  int ABITS     = 4,
    parameter  int DBITS     = 16,
    parameter  int BYTEWIDTH = 8,
    localparam int NBYTES    = DBITS / BYTEWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              we,
    output logic [ABITS-1:0]  wa,
    output logic [DBITS-1:0]  wd,
    output logic [NBYTES-1:0] be,
    output logic [ABITS-1:0]  ra,
    input  logic [DBITS-1:0]  rd,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_MASK  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ABITS-1:0] ADDR_MAX = '1;

    function automatic logic [31:0] lane_of(input logic [ABITS-1:0] a);
        return 32'(a) & 32'(NBYTES - 1);
    endfunction

    // Byte i of the fill word is the address XOR the lane index.
    function automatic logic [DBITS-1:0] pat_a(input logic [ABITS-1:0] a);
        logic [DBITS-1:0] w;
        w = '0;
        for (int i = 0; i < NBYTES; i++) begin
            w[i*BYTEWIDTH +: BYTEWIDTH] = BYTEWIDTH'(32'(a) ^ 32'(i));
        end
        return w;
    endfunction

    function automatic logic [DBITS-1:0] exp_word(input logic [ABITS-1:0] a);
        logic [DBITS-1:0] w;
        logic [DBITS-1:0] m;
        logic [31:0]      l;
        w = pat_a(a);
        m = ~w;
        l = lane_of(a);
        w[l*BYTEWIDTH +: BYTEWIDTH] = m[l*BYTEWIDTH +: BYTEWIDTH];
        return w;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ABITS-1:0]  addr_q, addr_d;
    logic              we_q, we_d;
    logic [ABITS-1:0]  wa_q, wa_d;
    logic [DBITS-1:0]  wd_q, wd_d;
    logic [NBYTES-1:0] be_q, be_d;
    logic [ABITS-1:0]  ra_q, ra_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic              pend_q, pend_d;
    logic [ABITS-1:0]  cmp_addr_q, cmp_addr_d;
    logic              mismatch_s;

    // Sequencing, error accounting and compare pipeline.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        mismatch_s = pend_q && (rd != exp_word(cmp_addr_q));
        if (mismatch_s && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end else begin
            err_d = err_q;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    addr_d  = '0;
                    err_d   = 16'd0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                addr_d = addr_q + ABITS'(1);
                if (addr_q == ADDR_MAX) begin
                    state_d = S_MASK;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_MASK: begin
                addr_d = addr_q + ABITS'(1);
                if (addr_q == ADDR_MAX) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_MASK;
                end
            end
            S_READ: begin
                addr_d = addr_q + ABITS'(1);
                if (addr_q == ADDR_MAX) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
`ifdef SDP_BE_TRAFFIC_GEN_STOP_ON_ERR_EN
                if (mismatch_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = state_d;
                end
`endif
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // The verdict includes the compare retiring on the same edge.
        if (state_d == S_DONE) begin
            pass_d = (err_d == 16'd0);
        end else begin
            pass_d = pass_d;
        end
        pend_d     = (state_q == S_READ) && (state_d != S_DONE);
        cmp_addr_d = ra_q;
    end

    // Port values are derived from the upcoming state so they appear in the state's own cycle.
    always_comb begin
        we_d   = 1'b0;
        wa_d   = wa_q;
        wd_d   = '0;
        be_d   = '0;
        ra_d   = ra_q;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_d)
            S_FILL: begin
                we_d = 1'b1;
                wa_d = addr_d;
                wd_d = pat_a(addr_d);
                be_d = '1;
            end
            S_MASK: begin
                we_d = 1'b1;
                wa_d = addr_d;
                wd_d = ~pat_a(addr_d);
                be_d = NBYTES'(1) << lane_of(addr_d);
            end
            S_READ:  ra_d = addr_d;
            default: ra_d = ra_q;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            be_q       <= '0;
            ra_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 16'd0;
            pend_q     <= 1'b0;
            cmp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            be_q       <= be_d;
            ra_q       <= ra_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            cmp_addr_q <= cmp_addr_d;
        end
    end

    assign we        = we_q;
    assign wa        = wa_q;
    assign wd        = wd_q;
    assign be        = be_q;
    assign ra        = ra_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule
